// File: rtl/nvdla_csb_arbiter.sv
// Round-robin arbiter/sequencer sharing one NVDLA CSB port between N_REQ requesters.
// Optional response timeout enabled by defining NVDLA_CSB_ARB_TIMEOUT_EN.
module nvdla_csb_arbiter #(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0]        req_addr_i,
    input  logic [N_REQ*32-1:0]            req_wdat_i,
    input  logic [N_REQ-1:0]               req_write_i,
    output logic [N_REQ-1:0]               rsp_valid_o,
    output logic [31:0]                    rsp_rdat_o,
    output logic                           rsp_err_o,
    output logic                           csb_valid_o,
    input  logic                           csb_ready_i,
    output logic [ADDR_W-1:0]              csb_addr_o,
    output logic [31:0]                    csb_wdat_o,
    output logic                           csb_write_o,
    output logic                           csb_nposted_o,
    input  logic                           csb_rvalid_i,
    input  logic [31:0]                    csb_rdata_i,
    input  logic                           csb_wr_complete_i,
    output logic                           busy_o,
    output logic [(N_REQ>1 ? $clog2(N_REQ) : 1)-1:0] grant_o
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_RESP
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [31:0]         wdat_reg;
    logic                write_reg;
    logic [GW-1:0]       grant_reg;
    logic [GW-1:0]       last_grant_reg;
    logic [31:0]         rdat_reg;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [31:0]         wdat_arr [N_REQ];

    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       cand;
    logic                accept;
    logic                cmpl_hit;
    logic [31:0]         cmpl_data;
    logic                timeout_hit;
    logic                resp_load;
    logic [31:0]         rdat_val;
    logic                resp_err_val;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign wdat_arr[gi] = req_wdat_i[gi*32 +: 32];
        end
    endgenerate

    // Search starts one past the last owner so every requester is served in turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int j = 1; j <= N_REQ; j++) begin
            cand = GW'((int'(last_grant_reg) + j) % N_REQ);
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign accept    = (state_reg == ST_IDLE) && win_found && !clear_i;
    assign cmpl_hit  = write_reg ? csb_wr_complete_i : csb_rvalid_i;
    assign cmpl_data = write_reg ? 32'h0 : csb_rdata_i;

    always_comb begin
        state_next   = state_reg;
        resp_load    = 1'b0;
        rdat_val     = cmpl_data;
        resp_err_val = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (timeout_hit) begin
                    state_next   = ST_RESP;
                    resp_load    = 1'b1;
                    rdat_val     = 32'hDEADBEEF;
                    resp_err_val = 1'b1;
                end else if (csb_ready_i) begin
                    // A completion accompanying the handshake skips WAIT_RSP.
                    if (cmpl_hit) begin
                        state_next = ST_RESP;
                        resp_load  = 1'b1;
                    end else begin
                        state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (cmpl_hit) begin
                    state_next = ST_RESP;
                    resp_load  = 1'b1;
                end else if (timeout_hit) begin
                    state_next   = ST_RESP;
                    resp_load    = 1'b1;
                    rdat_val     = 32'hDEADBEEF;
                    resp_err_val = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            wdat_reg       <= '0;
            write_reg      <= 1'b0;
            grant_reg      <= '0;
            last_grant_reg <= LAST_RST;
            rdat_reg       <= '0;
        end else if (clear_i) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            wdat_reg       <= '0;
            write_reg      <= 1'b0;
            grant_reg      <= '0;
            last_grant_reg <= LAST_RST;
            rdat_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= addr_arr[win_idx];
                wdat_reg  <= wdat_arr[win_idx];
                write_reg <= req_write_i[win_idx];
                grant_reg <= win_idx;
            end
            if (resp_load) rdat_reg <= rdat_val;
            if (state_reg == ST_RESP) last_grant_reg <= grant_reg;
        end
    end

`ifdef NVDLA_CSB_ARB_TIMEOUT_EN
    logic [15:0] cnt_reg;
    logic        err_reg;

    assign timeout_hit = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT_RSP))
                         && (cnt_reg == 16'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (clear_i) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (accept) begin
                cnt_reg <= '0;
            end else if ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT_RSP)) begin
                cnt_reg <= cnt_reg + 16'd1;
            end else begin
                cnt_reg <= '0;
            end
            if (resp_load) err_reg <= resp_err_val;
        end
    end

    assign rsp_err_o = err_reg;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign rsp_err_o      = 1'b0;
    assign unused_timeout = ^{resp_err_val, 32'(TIMEOUT_CYC)};
`endif

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (accept) req_ready_o[win_idx] = 1'b1;
        if ((state_reg == ST_RESP) && !clear_i) rsp_valid_o[grant_reg] = 1'b1;
    end

    assign rsp_rdat_o    = rdat_reg;
    assign csb_valid_o   = (state_reg == ST_ISSUE);
    assign csb_addr_o    = addr_reg;
    assign csb_wdat_o    = wdat_reg;
    assign csb_write_o   = write_reg;
    assign csb_nposted_o = 1'b1;
    assign busy_o        = (state_reg != ST_IDLE);
    assign grant_o       = grant_reg;

endmodule

// File: tb/tb_nvdla_csb_arbiter.sv
// Directed bench for nvdla_csb_arbiter: read, write with backpressure, fairness, clear, timeout.
module tb_nvdla_csb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req_addr_i;
    logic [63:0] req_wdat_i;
    logic [1:0]  req_write_i;
    logic [1:0]  rsp_valid_o;
    logic [31:0] rsp_rdat_o;
    logic        rsp_err_o;
    logic        csb_valid_o;
    logic        csb_ready_i;
    logic [15:0] csb_addr_o;
    logic [31:0] csb_wdat_o;
    logic        csb_write_o;
    logic        csb_nposted_o;
    logic        csb_rvalid_i;
    logic [31:0] csb_rdata_i;
    logic        csb_wr_complete_i;
    logic        busy_o;
    logic [0:0]  grant_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    nvdla_csb_arbiter #(
        .N_REQ      (2),
        .ADDR_W     (16),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_wdat_i       (req_wdat_i),
        .req_write_i      (req_write_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdat_o       (rsp_rdat_o),
        .rsp_err_o        (rsp_err_o),
        .csb_valid_o      (csb_valid_o),
        .csb_ready_i      (csb_ready_i),
        .csb_addr_o       (csb_addr_o),
        .csb_wdat_o       (csb_wdat_o),
        .csb_write_o      (csb_write_o),
        .csb_nposted_o    (csb_nposted_o),
        .csb_rvalid_i     (csb_rvalid_i),
        .csb_rdata_i      (csb_rdata_i),
        .csb_wr_complete_i(csb_wr_complete_i),
        .busy_o           (busy_o),
        .grant_o          (grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni            = 1'b0;
        clear_i           = 1'b0;
        req_valid_i       = '0;
        req_addr_i        = '0;
        req_wdat_i        = '0;
        req_write_i       = '0;
        csb_ready_i       = 1'b0;
        csb_rvalid_i      = 1'b0;
        csb_rdata_i       = '0;
        csb_wr_complete_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_csb_valid", 32'(csb_valid_o), 32'd0);
        chk("rst_nposted", 32'(csb_nposted_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_rdat", rsp_rdat_o, 32'd0);
        rst_ni = 1'b1;
        cyc();
        $display("reset released, idle check done");

        // Single read by requester 0
        req_valid_i = 2'b01;
        req_addr_i  = {16'h0000, 16'h1000};
        req_write_i = 2'b00;
        #1 chk("rd_ready", 32'(req_ready_o), 32'h1);
        cyc();
        req_valid_i = 2'b00;
        chk("rd_csb_valid", 32'(csb_valid_o), 32'd1);
        chk("rd_csb_addr", 32'(csb_addr_o), 32'h1000);
        chk("rd_csb_write", 32'(csb_write_o), 32'd0);
        chk("rd_busy", 32'(busy_o), 32'd1);
        csb_ready_i = 1'b1;
        cyc();
        csb_ready_i  = 1'b0;
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = 32'hCAFE0001;
        #1 chk("rd_no_early_rsp", 32'(rsp_valid_o), 32'd0);
        cyc();
        csb_rvalid_i = 1'b0;
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("rd_rsp_rdat", rsp_rdat_o, 32'hCAFE0001);
        chk("rd_rsp_err", 32'(rsp_err_o), 32'd0);
        cyc();
        chk("rd_rsp_pulse_end", 32'(rsp_valid_o), 32'd0);
        chk("rd_rdat_held", rsp_rdat_o, 32'hCAFE0001);
        chk("rd_idle", 32'(busy_o), 32'd0);
        $display("txn single read: req0 addr=1000 rdat=%h", rsp_rdat_o);

        // Single write by requester 1 with three cycles of backpressure
        req_valid_i = 2'b10;
        req_addr_i  = {16'h2004, 16'h0000};
        req_wdat_i  = {32'h12345678, 32'h0};
        req_write_i = 2'b10;
        #1 chk("wr_ready", 32'(req_ready_o), 32'h2);
        cyc();
        req_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            chk("wr_bp_valid", 32'(csb_valid_o), 32'd1);
            chk("wr_bp_addr", 32'(csb_addr_o), 32'h2004);
            chk("wr_bp_wdat", csb_wdat_o, 32'h12345678);
            chk("wr_bp_write", 32'(csb_write_o), 32'd1);
            cyc();
        end
        csb_ready_i = 1'b1;
        #1 chk("wr_valid_at_ready", 32'(csb_valid_o), 32'd1);
        chk("wr_nposted", 32'(csb_nposted_o), 32'd1);
        cyc();
        csb_ready_i  = 1'b0;
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = 32'hFFFFFFFF;
        cyc();
        csb_rvalid_i = 1'b0;
        #1 chk("wr_wrong_type_ignored", 32'(rsp_valid_o), 32'd0);
        chk("wr_still_busy", 32'(busy_o), 32'd1);
        chk("wr_valid_dropped", 32'(csb_valid_o), 32'd0);
        csb_wr_complete_i = 1'b1;
        cyc();
        csb_wr_complete_i = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'h2);
        chk("wr_rsp_rdat", rsp_rdat_o, 32'h0);
        chk("wr_grant", 32'(grant_o), 32'd1);
        cyc();
        $display("txn single write: req1 addr=2004 wdat=12345678");

        // Fairness with same-cycle completion: both requesters always valid
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_oh;
            exp_oh      = (k % 2 == 0) ? 2'b01 : 2'b10;
            req_valid_i = 2'b11;
            req_addr_i  = {16'h0200, 16'h0100};
            req_write_i = 2'b00;
            #1 chk("fair_ready", 32'(req_ready_o), 32'(exp_oh));
            cyc();
            chk("fair_grant", 32'(grant_o), 32'(k % 2));
            chk("fair_addr", 32'(csb_addr_o), (k % 2 == 0) ? 32'h0100 : 32'h0200);
            csb_ready_i  = 1'b1;
            csb_rvalid_i = 1'b1;
            csb_rdata_i  = 32'hA0000000 + 32'(k);
            cyc();
            csb_ready_i  = 1'b0;
            csb_rvalid_i = 1'b0;
            #1 chk("fair_rsp_valid", 32'(rsp_valid_o), 32'(exp_oh));
            chk("fair_rsp_rdat", rsp_rdat_o, 32'hA0000000 + 32'(k));
            chk("fair_no_ready_in_resp", 32'(req_ready_o), 32'd0);
            cyc();
            $display("txn fairness %0d: grant=%0d rdat=%h", k, k % 2, rsp_rdat_o);
        end
        req_valid_i = 2'b00;

        // Requester 0 write completing alongside the handshake
        req_valid_i = 2'b01;
        req_addr_i  = {16'h0000, 16'h3000};
        req_wdat_i  = {32'h0, 32'h00C0FFEE};
        req_write_i = 2'b01;
        cyc();
        req_valid_i       = 2'b00;
        csb_ready_i       = 1'b1;
        csb_wr_complete_i = 1'b1;
        cyc();
        csb_ready_i       = 1'b0;
        csb_wr_complete_i = 1'b0;
        chk("wr0_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("wr0_rsp_rdat", rsp_rdat_o, 32'h0);
        cyc();
        $display("txn write same-cycle: req0 addr=3000");

        // Clear in WAIT_RSP during a requester 1 read
        req_valid_i = 2'b10;
        req_addr_i  = {16'h4000, 16'h0000};
        req_write_i = 2'b00;
        cyc();
        req_valid_i = 2'b00;
        csb_ready_i = 1'b1;
        cyc();
        csb_ready_i = 1'b0;
        chk("clr_pre_busy", 32'(busy_o), 32'd1);
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("clr_idle", 32'(busy_o), 32'd0);
        chk("clr_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("clr_grant", 32'(grant_o), 32'd0);
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = 32'h0BADF00D;
        cyc();
        csb_rvalid_i = 1'b0;
        chk("clr_late_dropped", 32'(rsp_valid_o), 32'd0);
        chk("clr_late_idle", 32'(busy_o), 32'd0);
        req_valid_i = 2'b11;
        req_write_i = 2'b00;
        #1 chk("clr_prio_req0", 32'(req_ready_o), 32'h1);
        cyc();
        req_valid_i  = 2'b00;
        chk("clr_grant_req0", 32'(grant_o), 32'd0);
        csb_ready_i  = 1'b1;
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = 32'h00000055;
        cyc();
        csb_ready_i  = 1'b0;
        csb_rvalid_i = 1'b0;
        chk("clr_next_rsp", 32'(rsp_valid_o), 32'h1);
        chk("clr_next_rdat", rsp_rdat_o, 32'h00000055);
        cyc();
        $display("txn clear: dropped in-flight read, next grant req0");

`ifdef NVDLA_CSB_ARB_TIMEOUT_EN
        // Timeout: no completion ever returned
        req_valid_i = 2'b01;
        req_addr_i  = {16'h0000, 16'h5000};
        req_write_i = 2'b00;
        cyc();
        req_valid_i = 2'b00;
        csb_ready_i = 1'b1;
        cyc();
        csb_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("to_no_early_rsp", 32'(rsp_valid_o), 32'd0);
        end
        cyc();
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("to_rsp_err", 32'(rsp_err_o), 32'd1);
        chk("to_rsp_rdat", rsp_rdat_o, 32'hDEADBEEF);
        chk("to_csb_valid", 32'(csb_valid_o), 32'd0);
        csb_rvalid_i = 1'b1;
        csb_rdata_i  = 32'h11111111;
        cyc();
        chk("to_late_dropped0", 32'(rsp_valid_o), 32'd0);
        cyc();
        csb_rvalid_i = 1'b0;
        chk("to_late_dropped1", 32'(rsp_valid_o), 32'd0);
        chk("to_late_idle", 32'(busy_o), 32'd0);
        $display("txn timeout: req0 err=%0d rdat=%h", rsp_err_o, rsp_rdat_o);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
